xrv_mem_arb: RTL
================

// Module: xrv_mem_arb
// PURPOSE
//  Arbitrates one shared single-port memory bus between instruction fetch (IF) and load/store (LS).
//  Sits between fetch/LSU and memory. Feeds ls_done to the pipeline stall logic and consumes its flush.
//  One outstanding transaction at a time. Fixed priority: LS over IF. Flushed fetches are discarded.
// PARAMETERS
//  AW           32   address width
//  DW           32   data width (byte enables = DW/8)
//  TIMEOUT_CYC  255  ack watchdog limit in cycles; used only with XRV_ARB_TIMEOUT_EN
// PORTS
//  clk        in   1     clock
//  rstb       in   1     asynchronous active-low reset
//  flush      in   1     pipeline flush (jump taken); cancels fetch
//  if_req     in   1     fetch request; held until if_gnt
//  if_addr    in   AW    fetch address
//  if_gnt     out  1     fetch request captured (1-cycle pulse)
//  if_rvalid  out  1     fetch data valid (1-cycle pulse)
//  if_rdata   out  DW    fetch data
//  ls_req     in   1     load/store request; held until ls_gnt
//  ls_we      in   1     1 = store
//  ls_be      in   DW/8  byte enables
//  ls_addr    in   AW    LS address
//  ls_wdata   in   DW    store data
//  ls_gnt     out  1     LS request captured (1-cycle pulse)
//  ls_done    out  1     LS complete; load data valid (1-cycle pulse)
//  ls_rdata   out  DW    load data
//  mem_req    out  1     bus request; held until mem_ack
//  mem_we/be/addr/wdata  out  1/DW/8/AW/DW  registered bus command
//  mem_ack    in   1     bus completion; mem_rdata valid this cycle
//  mem_rdata  in   DW    bus read data
//  bus_err    out  1     watchdog abort pulse (tied 0 without macro)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, including mem_* command regs and rdata outputs.
//  States: IDLE, LS_BUSY, IF_BUSY, IF_DROP.
//  Arbitration (IDLE, or ack cycle of any busy state): ls_req wins; else if_req && !flush wins.
//   Winner: gnt pulses combinationally that cycle; command registered; mem_req=1 from next cycle.
//   No winner: go IDLE, mem_req=0 next cycle.
//  Latency: req accepted cycle N -> mem_req cycle N+1 -> earliest ack N+1 -> done/rvalid on ack cycle.
//  Back-to-back: ack cycle re-arbitrates; next command issued with no idle bubble.
//  LS_BUSY: on mem_ack, ls_done=1, ls_rdata=mem_rdata (0 for stores). flush does not affect LS.
//  IF_BUSY: on mem_ack, if_rvalid=1, if_rdata=mem_rdata, unless flush is high that cycle (suppressed).
//   flush while IF_BUSY without ack -> IF_DROP.
//  IF_DROP: mem_req held; on mem_ack, no if_rvalid; re-arbitrate normally.
//  flush in IDLE with if_req: fetch not granted; LS still granted.
//  mem_req never deasserts before mem_ack, except on watchdog abort.
//  rdata outputs hold their last value outside valid pulses.
//  Reset mid-transaction: immediate return to IDLE, mem_req=0; the outstanding ack is not tracked.
// CONFIGURATION
//  XRV_ARB_TIMEOUT_EN defined:
//   - Counter clears on each issue and counts busy cycles.
//   - At TIMEOUT_CYC cycles without ack: mem_req drops; bus_err pulses.
//   - The same cycle pulses the owner's ls_done/if_rvalid with rdata=0; IF_DROP pulses only bus_err.
//   - Next state is IDLE.
//  XRV_ARB_TIMEOUT_EN undefined: no counter; bus_err=0; waits forever on ack.
// STRUCTURE
//  xrv_pkg: arb_state_t enum (IDLE, LS_BUSY, IF_BUSY, IF_DROP), XRV_AW/XRV_DW defaults.
//  Sub-module xrv_arb_wdog (counter + expiry), instantiated only under XRV_ARB_TIMEOUT_EN.
// TESTING
//  1 Single fetch, if_addr=0x100, ack 2 cycles after mem_req: if_gnt@N, mem_req N+1..N+2, if_rvalid@N+2.
//  2 if_req and ls_req same cycle, ls_addr=0x2000: LS granted first; IF granted on LS ack, no bubble.
//  3 Store be=0x3 wdata=0xDEADBEEF: mem_we=1, mem_be=0x3; ls_done on ack, ls_rdata=0.
//  4 flush 1 cycle after fetch issue, ack 3 cycles later: no if_rvalid; IF_DROP->IDLE.
//  5 flush on fetch ack cycle with ls_req high: if_rvalid suppressed; LS granted that cycle.
//  6 Macro on, TIMEOUT_CYC=4, no ack: LS aborts after 4 busy cycles; bus_err=ls_done=1, rdata 0, IDLE.
//    Reset asserted mid-LS_BUSY: all outputs 0 immediately.

Source files
------------

// File: rtl/xrv_pkg.sv
// rtl/xrv_pkg.sv - shared types and defaults for the memory arbiter
package xrv_pkg;

    localparam int XRV_AW = 32;
    localparam int XRV_DW = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LS_BUSY = 2'd1,
        IF_BUSY = 2'd2,
        IF_DROP = 2'd3
    } arb_state_t;

endpackage

// File: rtl/xrv_arb_wdog.sv
// rtl/xrv_arb_wdog.sv - ack watchdog: counts busy cycles, flags expiry on the last allowed cycle
module xrv_arb_wdog #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rstb,
    input  logic clr,
    input  logic busy,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    // cnt holds the number of busy cycles already spent, so expiry lands on busy cycle TIMEOUT_CYC
    assign expire = busy && (cnt == CW'(TIMEOUT_CYC - 1));

    // count busy cycles since the last issue; a fresh issue restarts the count
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (busy && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/xrv_mem_arb.sv
// rtl/xrv_mem_arb.sv - IF/LS arbiter for one shared memory bus; watchdog under XRV_ARB_TIMEOUT_EN
module xrv_mem_arb
    import xrv_pkg::*;
#(
    parameter int AW          = XRV_AW,
    parameter int DW          = XRV_DW,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rstb,
    input  logic            flush,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [DW/8-1:0] ls_be,
    input  logic [AW-1:0]   ls_addr,
    input  logic [DW-1:0]   ls_wdata,
    output logic            ls_gnt,
    output logic            ls_done,
    output logic [DW-1:0]   ls_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata,
    output logic            bus_err
);

    arb_state_t    state;
    logic          busy;
    logic          ack_now;
    logic          abort;
    logic          arb_en;
    logic          pick_ls;
    logic          pick_if;
    logic [DW-1:0] ls_val;
    logic [DW-1:0] if_val;
    logic [DW-1:0] ls_rdata_q;
    logic [DW-1:0] if_rdata_q;

    assign busy    = (state != IDLE);
    assign ack_now = busy && mem_ack;

    // arbitration happens when idle or on the ack cycle; rstb gating keeps grants quiet during reset
    assign arb_en  = rstb && ((state == IDLE) || ack_now);
    assign pick_ls = arb_en && ls_req;
    assign pick_if = arb_en && !ls_req && if_req && !flush;

    assign ls_gnt  = pick_ls;
    assign if_gnt  = pick_if;

    // completion pulses come straight off the ack (or abort) so the pipeline sees them that cycle
    assign ls_done   = (state == LS_BUSY) && (ack_now || abort);
    assign if_rvalid = (state == IF_BUSY) && !flush && (ack_now || abort);

    // stores and aborted transfers return zero data
    assign ls_val = (abort || mem_we) ? '0 : mem_rdata;
    assign if_val = abort ? '0 : mem_rdata;

    // data is visible in the pulse cycle and held from the registers afterwards
    assign ls_rdata = ls_done   ? ls_val : ls_rdata_q;
    assign if_rdata = if_rvalid ? if_val : if_rdata_q;

`ifdef XRV_ARB_TIMEOUT_EN
    xrv_arb_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .rstb   (rstb),
        .clr    (pick_ls || pick_if),
        .busy   (busy && !mem_ack),
        .expire (abort)
    );
    assign bus_err = abort;
`else
    localparam int timeout_unused = TIMEOUT_CYC;
    assign abort   = 1'b0;
    assign bus_err = 1'b0;
`endif

    // FSM: latch the winning command, hold mem_req until ack or abort, track flushed fetches
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ls_rdata_q <= '0;
            if_rdata_q <= '0;
        end else begin
            if (ls_done) begin
                ls_rdata_q <= ls_val;
            end
            if (if_rvalid) begin
                if_rdata_q <= if_val;
            end

            if (abort) begin
                state   <= IDLE;
                mem_req <= 1'b0;
            end else if (pick_ls) begin
                state     <= LS_BUSY;
                mem_req   <= 1'b1;
                mem_we    <= ls_we;
                mem_be    <= ls_be;
                mem_addr  <= ls_addr;
                mem_wdata <= ls_wdata;
            end else if (pick_if) begin
                state     <= IF_BUSY;
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_be    <= '1;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end else if (arb_en) begin
                state   <= IDLE;
                mem_req <= 1'b0;
            end else if ((state == IF_BUSY) && flush) begin
                state <= IF_DROP;
            end
        end
    end

endmodule
